div_2in: RTL

Sequential signed fixed-point divider: the inverse of the ANN datapath's two-input fixed-point multiplier, in the same Q-format (WIDTH total bits, FRAC fraction bits, two's complement). It computes o_q = round(i_a / i_b) with a start/valid handshake, one quotient bit per cycle. It serves normalisation and learning-rate scaling in the backprop path, where a single-cycle divider is not affordable.

---
 rtl/div_2in_pkg.sv | 47 ++++
 rtl/div_2in_divu_step.sv | 26 ++
 rtl/div_2in.sv | 119 +++++++++++
 3 files changed

// File: rtl/div_2in_pkg.sv
// div_2in_pkg -- shared definitions for the fixed-point divider and the
// ANN multiplier path.
//   state_e         : divider FSM states (IDLE, CALC, ROUND)
//   WIDTH/FRAC/N    : default Q-format and iteration count
//   QMAX/QMIN       : saturation limits for the default width
//   qmax_f/qmin_f   : the same limits for an arbitrary width
//   round_sat       : round-half-up a magnitude that carries one extra
//                     fraction bit, clamp it and apply the sign
package div_2in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2
  } state_e;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned N     = WIDTH + FRAC + 1;

  function automatic logic signed [63:0] qmax_f(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] qmin_f(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [63:0] QMAX = qmax_f(WIDTH);
  localparam logic signed [63:0] QMIN = qmin_f(WIDTH);

  // q holds the magnitude with one extra fraction bit, so (q+1)>>1 rounds half
  // up on the magnitude, which is half away from zero once the sign goes on.
  // A negative result may reach magnitude 2^(w-1); a positive one only
  // 2^(w-1)-1. The return value is w-bit two's complement in the low bits.
  function automatic logic [63:0] round_sat(input logic [63:0] q,
                                            input logic        neg,
                                            input int unsigned w);
    logic [63:0] m;
    logic [63:0] lim;
    m   = (q + 64'd1) >> 1;
    lim = neg ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    if (m > lim) m = lim;
    return neg ? (~m + 64'd1) : m;
  endfunction

endpackage

// File: rtl/div_2in_divu_step.sv
// div_2in_divu_step -- one combinational restoring-division step.
//   rem_i  : partial remainder (W+1 bits)
//   b_i    : unsigned divisor magnitude (W bits)
//   bit_i  : next dividend bit, shifted in at the LSB
//   rem_o  : updated remainder
//   qbit_o : quotient bit produced by this step
module divu_step #(
  parameter int W = 24
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] b_i,
  input  logic         bit_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W+1:0] sh;
  logic [W+1:0] diff;

  // One guard bit above the remainder so the subtraction borrow is visible.
  assign sh     = {rem_i, bit_i};
  assign diff   = sh - {2'b00, b_i};
  assign qbit_o = ~diff[W+1];
  assign rem_o  = qbit_o ? diff[W:0] : sh[W:0];

endmodule

// File: rtl/div_2in.sv
// div_2in -- sequential signed fixed-point divider, o_q = round(i_a / i_b),
// one quotient bit per cycle, fixed latency N+1 cycles from accept.
//   clk, rst  : clock, asynchronous active-high reset
//   i_start   : request, sampled only while idle
//   i_a, i_b  : dividend / divisor, signed Q(WIDTH-FRAC).FRAC
//   o_q       : quotient, held until the next result
//   o_valid   : one-cycle pulse when o_q/o_div0 update
//   o_busy    : division in progress (CALC and ROUND)
//   o_div0    : divisor was zero; held with o_q
module div_2in
  import div_2in_pkg::*;
#(
  parameter int WIDTH = div_2in_pkg::WIDTH,
  parameter int FRAC  = div_2in_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_div0
);

  localparam int NI = WIDTH + FRAC + 1;   // iterations = quotient bits
  localparam int CW = $clog2(NI + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic             div0_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   rem_q;
  logic [NI-1:0]    dvd_q;   // |a| followed by FRAC+1 zero bits, MSB first
  logic [NI-1:0]    quo_q;

  logic [WIDTH:0]   rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [63:0]      rs;
  logic [WIDTH-1:0] res;
  logic             unused_rs;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit number.
  assign a_mag = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
  assign b_mag = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;

  divu_step #(.W(WIDTH)) u_step (
    .rem_i  (rem_q),
    .b_i    (b_q),
    .bit_i  (dvd_q[NI-1]),
    .rem_o  (rem_d),
    .qbit_o (qbit_d)
  );

  assign rs        = round_sat(64'(quo_q), sign_q, WIDTH);
  assign unused_rs = ^rs[63:WIDTH];

  // With a zero divisor the sign reduces to the dividend sign, so the
  // saturation limit follows i_a's polarity.
  always_comb begin
    res = rs[WIDTH-1:0];
    if (div0_q) res = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      div0_q  <= 1'b0;
      b_q     <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      o_q     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_div0  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= CALC;
            cnt_q   <= CW'(NI);
            sign_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            div0_q  <= (i_b == '0);
            b_q     <= b_mag;
            rem_q   <= '0;
            dvd_q   <= {a_mag, {(FRAC+1){1'b0}}};
            quo_q   <= '0;
            o_busy  <= 1'b1;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[NI-2:0], qbit_d};
          dvd_q <= {dvd_q[NI-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= ROUND;
        end
        ROUND: begin
          o_q     <= res;
          o_div0  <= div0_q;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
